// File: rtl/imem_arbiter_if.sv
// Bus bundle for imem_arbiter: fetch and debug request/response channels,
// the shared instruction memory port, and the starvation counter for debug.
interface imem_arbiter_if #(
  parameter int A_WIDTH  = 32,
  parameter int D_WIDTH  = 32,
  parameter int SC_WIDTH = 3
);
  logic               f_req_valid;
  logic               f_req_ready;
  logic [A_WIDTH-1:0] f_addr;
  logic               f_resp_valid;
  logic [D_WIDTH-1:0] f_resp_data;
  logic               f_resp_err;

  logic               d_req_valid;
  logic               d_req_ready;
  logic [A_WIDTH-1:0] d_addr;
  logic               d_resp_valid;
  logic [D_WIDTH-1:0] d_resp_data;
  logic               d_resp_err;

  logic [A_WIDTH-1:0] mem_a;
  logic [D_WIDTH-1:0] mem_rd;

  logic [SC_WIDTH-1:0] dbg_starve_cnt;

  // Arbiter side.
  modport slave (
    input  f_req_valid, f_addr, d_req_valid, d_addr, mem_rd,
    output f_req_ready, f_resp_valid, f_resp_data, f_resp_err,
    output d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
    output mem_a, dbg_starve_cnt
  );

  // Requesters plus memory side.
  modport master (
    output f_req_valid, f_addr, d_req_valid, d_addr, mem_rd,
    input  f_req_ready, f_resp_valid, f_resp_data, f_resp_err,
    input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
    input  mem_a, dbg_starve_cnt
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares one combinational-read instruction memory port between fetch (F) and
// debug (D): F has priority, bounded by a starvation limit; 1-cycle responses.
module imem_arbiter #(
  parameter int A_WIDTH     = 32,
  parameter int D_WIDTH     = 32,
  parameter int MAX_F_BURST = 4
) (
  input logic          clk,
  input logic          rst,
  imem_arbiter_if.slave bus
);
  localparam int SC_W = $clog2(MAX_F_BURST + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_F_BURST);

  // Handshake: a request transfers when valid && ready; ready is combinational
  // from the valids and starve_cnt; responses have no backpressure.
  logic               f_grant;
  logic               d_grant;
  logic [A_WIDTH-1:0] mem_a_c;
  logic [SC_W-1:0]    starve_cnt_q, starve_cnt_d;

  logic               f_resp_valid_q, f_resp_valid_d;
  logic [D_WIDTH-1:0] f_resp_data_q,  f_resp_data_d;
  logic               f_resp_err_q,   f_resp_err_d;
  logic               d_resp_valid_q, d_resp_valid_d;
  logic [D_WIDTH-1:0] d_resp_data_q,  d_resp_data_d;
  logic               d_resp_err_q,   d_resp_err_d;

  // Arbitration and starvation counter; kept apart from the response logic so
  // the mem_a -> mem_rd path does not fold back into one block.
  always_comb begin
    f_grant      = 1'b0;
    d_grant      = 1'b0;
    mem_a_c      = '0;
    starve_cnt_d = starve_cnt_q;
    if (!rst) begin
      if (bus.d_req_valid && (!bus.f_req_valid || starve_cnt_q == SC_MAX)) begin
        d_grant = 1'b1;
      end else if (bus.f_req_valid) begin
        f_grant = 1'b1;
      end
    end
    if (f_grant) begin
      mem_a_c = bus.f_addr;
    end else if (d_grant) begin
      mem_a_c = bus.d_addr;
    end
    if (d_grant || !bus.d_req_valid) begin
      starve_cnt_d = '0;
    end else if (f_grant && starve_cnt_q != SC_MAX) begin
      starve_cnt_d = starve_cnt_q + SC_W'(1);
    end
  end

  // Data and error hold their last value on a side that is not granted.
  always_comb begin
    f_resp_valid_d = f_grant;
    f_resp_data_d  = f_resp_data_q;
    f_resp_err_d   = f_resp_err_q;
    d_resp_valid_d = d_grant;
    d_resp_data_d  = d_resp_data_q;
    d_resp_err_d   = d_resp_err_q;
    if (f_grant) begin
      f_resp_data_d = bus.mem_rd;
      f_resp_err_d  = (bus.f_addr[1:0] != 2'b00);
    end
    if (d_grant) begin
      d_resp_data_d = bus.mem_rd;
      d_resp_err_d  = (bus.d_addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q   <= '0;
      f_resp_valid_q <= 1'b0;
      f_resp_data_q  <= '0;
      f_resp_err_q   <= 1'b0;
      d_resp_valid_q <= 1'b0;
      d_resp_data_q  <= '0;
      d_resp_err_q   <= 1'b0;
    end else begin
      starve_cnt_q   <= starve_cnt_d;
      f_resp_valid_q <= f_resp_valid_d;
      f_resp_data_q  <= f_resp_data_d;
      f_resp_err_q   <= f_resp_err_d;
      d_resp_valid_q <= d_resp_valid_d;
      d_resp_data_q  <= d_resp_data_d;
      d_resp_err_q   <= d_resp_err_d;
    end
  end

  assign bus.f_req_ready    = f_grant;
  assign bus.d_req_ready    = d_grant;
  assign bus.mem_a          = mem_a_c;
  assign bus.f_resp_valid   = f_resp_valid_q;
  assign bus.f_resp_data    = f_resp_data_q;
  assign bus.f_resp_err     = f_resp_err_q;
  assign bus.d_resp_valid   = d_resp_valid_q;
  assign bus.d_resp_data    = d_resp_data_q;
  assign bus.d_resp_err     = d_resp_err_q;
  assign bus.dbg_starve_cnt = starve_cnt_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios then random traffic, checked
// against a reference model built from the arbitration and response rules.
module tb_imem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MFB = 4;
  localparam int SCW = $clog2(MFB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  imem_arbiter_if #(.A_WIDTH(AW), .D_WIDTH(DW), .SC_WIDTH(SCW)) bus ();

  imem_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW), .MAX_F_BURST(MFB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / memory
  always #5 clk = ~clk;

  logic [DW-1:0] rom [64];
  assign bus.mem_rd = rom[bus.mem_a[7:2]];

  // scoreboard: {is_d, err, data} of the grant awaiting its response
  logic [DW+1:0] exp_q[$];
  int            f_streak = 0;
  logic [DW-1:0] last_f_data = '0, last_d_data = '0;
  logic          last_f_err = 1'b0, last_d_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one clock cycle with given inputs, model prediction and checks
  task automatic cycle(input logic r, input logic fv, input logic [AW-1:0] fa,
                       input logic dv, input logic [AW-1:0] da, output logic d_got);
    logic          gf, gd, has;
    logic [AW-1:0] ga;
    logic [DW+1:0] e;
    @(negedge clk);
    rst = r;
    bus.f_req_valid = fv;
    bus.f_addr      = fa;
    bus.d_req_valid = dv;
    bus.d_addr      = da;
    #1;
    gd = !r && dv && (!fv || f_streak >= MFB);
    gf = !r && fv && !gd;
    ga = gf ? fa : (gd ? da : '0);
    d_got = bus.d_req_ready;
    chk("f_req_ready", 64'(bus.f_req_ready), 64'(gf));
    chk("d_req_ready", 64'(bus.d_req_ready), 64'(gd));
    chk("mem_a", 64'(bus.mem_a), 64'(ga));
    chk("starve_cnt", 64'(bus.dbg_starve_cnt), 64'(f_streak));

    has = (exp_q.size() != 0);
    e   = '0;
    if (has) begin
      e = exp_q.pop_front();
      if (e[DW+1]) begin
        last_d_err = e[DW]; last_d_data = e[DW-1:0];
      end else begin
        last_f_err = e[DW]; last_f_data = e[DW-1:0];
      end
    end
    chk("f_resp_valid", 64'(bus.f_resp_valid), 64'(has && !e[DW+1]));
    chk("d_resp_valid", 64'(bus.d_resp_valid), 64'(has && e[DW+1]));
    chk("f_resp_data", 64'(bus.f_resp_data), 64'(last_f_data));
    chk("f_resp_err", 64'(bus.f_resp_err), 64'(last_f_err));
    chk("d_resp_data", 64'(bus.d_resp_data), 64'(last_d_data));
    chk("d_resp_err", 64'(bus.d_resp_err), 64'(last_d_err));

    if (r) begin
      exp_q.delete();
      f_streak = 0;
      last_f_data = '0; last_d_data = '0;
      last_f_err = 1'b0; last_d_err = 1'b0;
    end else begin
      if (gf || gd) exp_q.push_back({gd, (ga[1:0] != 2'b00), rom[ga[7:2]]});
      if (gd || !dv) f_streak = 0;
      else if (gf && f_streak < MFB) f_streak++;
    end
    @(posedge clk);
  endtask

  function automatic logic [AW-1:0] rnd_addr(input bit allow_mis);
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 63)) << 2;
    if (allow_mis && $urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    logic       g;
    logic [9:0] pat;
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000 + i;
    bus.f_req_valid = 1'b0; bus.f_addr = '0;
    bus.d_req_valid = 1'b0; bus.d_addr = '0;

    // reset with requests pending: no grants, mem_a = 0
    cycle(1'b1, 1'b1, 32'h4, 1'b1, 32'h8, g);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, g);

    // F only, then idle
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, g);
    cycle(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, g);
    cycle(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, g);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, g);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, g);

    // continuous contention: F,F,F,F,D,F,F,F,F,D
    pat = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, rnd_addr(0), 1'b1, rnd_addr(0), g);
      chk("grant_pattern", 64'(g), 64'(pat[i]));
    end

    // D alone, then contention restarts with four F grants
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, g);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, g);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, rnd_addr(0), 1'b1, rnd_addr(0), g);
      chk("restart_pattern", 64'(g), 64'(i == 4));
    end

    // misaligned fetch, then aligned
    cycle(1'b0, 1'b1, 32'h6, 1'b0, 32'h0, g);
    cycle(1'b0, 1'b1, 32'h8, 1'b0, 32'h0, g);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, g);

    // reset mid-operation
    cycle(1'b0, 1'b1, 32'hC, 1'b1, 32'h20, g);
    cycle(1'b1, 1'b1, 32'h10, 1'b1, 32'h24, g);
    cycle(1'b0, 1'b1, 32'h14, 1'b1, 32'h28, g);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, g);

    // D withdraws before being granted
    cycle(1'b0, 1'b1, 32'h30, 1'b1, 32'h40, g);
    cycle(1'b0, 1'b1, 32'h34, 1'b1, 32'h40, g);
    cycle(1'b0, 1'b1, 32'h38, 1'b0, 32'h0, g);
    cycle(1'b0, 1'b1, 32'h3C, 1'b0, 32'h0, g);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, g);

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), rnd_addr(1),
            ($urandom_range(0, 1) == 1), rnd_addr(1), g);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, g);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
